// File: rtl/pow_pkg.sv
// pow_pkg: shared state enum and default operand widths for the power unit
package pow_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_EXP_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, CALC, DONE} pow_state_t;
endpackage

// File: rtl/pow_mul_trunc.sv
// pow_mul_trunc: combinational multiply; x,y in -> low-half product p, hi_nz flags nonzero upper half
module pow_mul_trunc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p,
  output logic             hi_nz
);
  logic [2*WIDTH-1:0] full;
  assign full = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
  assign p = full[WIDTH-1:0];
  assign hi_nz = |full[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/pow_seq.sv
// pow_seq: LSB-first square-and-multiply a**b mod 2^WIDTH; in_valid/in_ready/a/b in, out_valid/out_ready/result/ovf out, busy in CALC/DONE
module pow_seq
  import pow_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [EXP_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic                 busy
);
  pow_state_t state, nxt;
  logic [WIDTH-1:0] acc, base, acc_p, sq_p;
  logic [EXP_WIDTH-1:0] exp_q, exp_nx;
  logic ovf_q, acc_hi, sq_hi;
  pow_mul_trunc #(.WIDTH(WIDTH)) u_acc (.x(acc), .y(base), .p(acc_p), .hi_nz(acc_hi));
  pow_mul_trunc #(.WIDTH(WIDTH)) u_sq (.x(base), .y(base), .p(sq_p), .hi_nz(sq_hi));
  assign exp_nx = exp_q >> 1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (in_valid ? ((b == '0) ? DONE : CALC) : IDLE) :
          (state == CALC) ? ((exp_nx == '0) ? DONE : CALC) :
          (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    result = acc;
    ovf = ovf_q;
  end
  // a base-square overflow only matters if that base will be used again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      base <= '0;
      exp_q <= '0;
      ovf_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      acc <= WIDTH'(1);
      base <= a;
      exp_q <= b;
      ovf_q <= 1'b0;
    end else if (state == CALC) begin
      if (exp_q[0]) acc <= acc_p;
      base <= sq_p;
      exp_q <= exp_nx;
      ovf_q <= ovf_q | (exp_q[0] & acc_hi) | (sq_hi & (exp_nx != '0));
    end
  end
endmodule

// File: tb/tb_pow_seq.sv
// tb_pow_seq: directed scoreboard bench for pow_seq
module tb_pow_seq;
  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, ovf, busy;
  logic [31:0] result;
  int checks = 0, failures = 0;
  exp_t sb[$];
  pow_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic int lat_of(input logic [31:0] e);
    int l = 0;
    for (int i = 0; i < 32; i++) if (e[i]) l = i + 1;
    return (e == 0) ? 1 : l + 1;
  endfunction
  task automatic push(input logic [31:0] bb, input logic [31:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.lat = lat_of(bb);
    sb.push_back(e);
  endtask
  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] r, input logic o);
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    a = aa;
    b = bb;
    in_valid = 1;
    push(bb, r, o);
    @(negedge clk);
    in_valid = 0;
    a = 32'hDEAD_BEEF;
    b = 32'h5;
  endtask
  task automatic wait_result();
    int cyc = 1;
    exp_t e;
    while (!out_valid && cyc < 40) begin
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_timeout", out_valid, 1);
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("result", result, e.res);
    chk("ovf", ovf, e.ovf);
    chk("busy_done", busy, 1);
  endtask
  task automatic handshake();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    issue(3, 4, 81, 0); wait_result(); handshake();
    chk("idle_keeps_result", result, 81);
    issue(5, 0, 1, 0); wait_result(); handshake();
    issue(0, 0, 1, 0); wait_result(); handshake();
    issue(2, 31, 32'h8000_0000, 0); wait_result(); handshake();
    issue(2, 32, 0, 1); wait_result(); handshake();
    chk("idle_keeps_ovf", ovf, 1);
    issue(1, 32'hFFFF_FFFF, 1, 0); wait_result(); handshake();
    issue(0, 7, 0, 0); wait_result(); handshake();
    issue(3, 5, 243, 0); wait_result(); handshake();
    issue(7, 2, 49, 0); wait_result();
    a = 3;
    b = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 49);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("b2b_drop", out_valid, 0);
    chk("b2b_in_ready", in_ready, 1);
    push(1, 3, 0);
    @(negedge clk);
    in_valid = 0;
    chk("b2b_accepted", in_ready, 0);
    wait_result(); handshake();
    @(negedge clk);
    a = 3;
    b = 32'hFF;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("calc_busy", busy, 1);
    rst = 1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_out_after_abort", out_valid, 0);
    end
    issue(2, 10, 1024, 0); wait_result(); handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
